// File: rtl/uart_pkg.sv
// uart_pkg: constants, state encodings and helpers shared by the UART receive and transmit blocks.
//   UART_OVERSAMPLE  baud_16_x_p ticks per serial bit
//   UART_FIFO_DEPTH  receive FIFO depth in bytes
//   TICK_SAMPLE_*    tick indices whose samples are majority-voted into one bit
//   rx_state_e       receiver FSM states
//   tx_state_e       transmitter FSM states
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_FIFO_DEPTH = 32;

    localparam logic [3:0] TICK_SAMPLE_0 = 4'd7;
    localparam logic [3:0] TICK_SAMPLE_1 = 4'd8;
    localparam logic [3:0] TICK_SAMPLE_2 = 4'd9;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_PUSH,
        RX_BREAK
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side host interface of the UART receiver.
//   fifo_rx_rd_en_p       pop one byte (host -> receiver)
//   error_clear_p         clear the sticky error flags (host -> receiver)
//   fifo_rx_dout_p        popped byte, valid the clock after a pop
//   fifo_rx_data_count_p  bytes held, 0..32
//   fifo_rx_empty_p       FIFO empty
//   fifo_rx_full_p        FIFO full
//   rx_byte_valid_p       one-clk pulse per byte written into the FIFO
//   framing_error_p       sticky, stop bit sampled low
//   overrun_p             sticky, good byte dropped on a full FIFO
// master = receiver side, slave = host side.
interface uart_rx_if;

    logic       fifo_rx_rd_en_p;
    logic       error_clear_p;
    logic [7:0] fifo_rx_dout_p;
    logic [5:0] fifo_rx_data_count_p;
    logic       fifo_rx_empty_p;
    logic       fifo_rx_full_p;
    logic       rx_byte_valid_p;
    logic       framing_error_p;
    logic       overrun_p;

    modport master (
        input  fifo_rx_rd_en_p,
        input  error_clear_p,
        output fifo_rx_dout_p,
        output fifo_rx_data_count_p,
        output fifo_rx_empty_p,
        output fifo_rx_full_p,
        output rx_byte_valid_p,
        output framing_error_p,
        output overrun_p
    );

    modport slave (
        output fifo_rx_rd_en_p,
        output error_clear_p,
        input  fifo_rx_dout_p,
        input  fifo_rx_data_count_p,
        input  fifo_rx_empty_p,
        input  fifo_rx_full_p,
        input  rx_byte_valid_p,
        input  framing_error_p,
        input  overrun_p
    );

endinterface

// File: rtl/fifo_rx.sv
// fifo_rx: synchronous byte FIFO with standard (registered) read mode and a data count.
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_wr_en       write i_wr_data (ignored while full)
//   i_wr_data     byte to write
//   i_rd_en       pop one byte into o_dout (ignored while empty)
//   o_dout        popped byte, updated the clock after i_rd_en
//   o_data_count  bytes held, 0..DEPTH
//   o_empty       holds 0 bytes
//   o_full        holds DEPTH bytes
module fifo_rx #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [7:0]                 i_wr_data,
    input  logic                       i_rd_en,
    output logic [7:0]                 o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_data_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_d;
    logic          r_empty;
    logic          r_full;
    logic [7:0]    r_dout;
    logic          w_do_wr;
    logic          w_do_rd;

    assign w_do_wr = i_wr_en & ~r_full;
    assign w_do_rd = i_rd_en & ~r_empty;

    always_comb begin
        w_count_d = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_dout   <= 8'h00;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_d;
            r_empty <= (w_count_d == '0);
            r_full  <= (w_count_d == CW'(DEPTH));
        end
    end

    assign o_dout       = r_dout;
    assign o_data_count = r_count;
    assign o_empty      = r_empty;
    assign o_full       = r_full;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, majority-vote bit decisions and a
// 32-byte receive FIFO.
//   clk210_p     sole clock, rising edge
//   reset_p      synchronous active-high reset
//   baud_16_x_p  one-clk strobe at 16x the baud rate
//   rx_p         asynchronous serial input, idle high, LSB first
//   bus          uart_rx_if.master: FIFO read port, status and sticky error flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk210_p,
    input  logic       reset_p,
    input  logic       baud_16_x_p,
    input  logic       rx_p,
    uart_rx_if.master  bus
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    logic       r_rx_meta;
    logic       r_rx_s;
    rx_state_e  r_state;
    logic [3:0] r_tick;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [1:0] r_samp;
    logic       r_wr_en;
    logic       r_valid;
    logic       r_framing_err;
    logic       r_overrun;
    logic [3:0] w_tick_nxt;
    logic       w_maj;
    logic       w_in_bit;

    // r_tick holds the index of the last processed tick; the current tick is one past it,
    // and the 4-bit wrap makes tick 15 of one bit roll into tick 0 of the next.
    assign w_tick_nxt = r_tick + 4'd1;
    assign w_maj      = majority3(r_samp[0], r_samp[1], r_rx_s);
    assign w_in_bit   = (r_state == RX_START) || (r_state == RX_DATA) || (r_state == RX_STOP);

    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            r_rx_meta     <= 1'b1;
            r_rx_s        <= 1'b1;
            r_state       <= RX_IDLE;
            r_tick        <= 4'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_samp        <= 2'b11;
            r_wr_en       <= 1'b0;
            r_valid       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_rx_meta <= rx_p;
            r_rx_s    <= r_rx_meta;
            r_wr_en   <= 1'b0;
            r_valid   <= 1'b0;

            // Clear first so a flag set later in this block wins.
            if (bus.error_clear_p) begin
                r_framing_err <= 1'b0;
                r_overrun     <= 1'b0;
            end

            if (baud_16_x_p && w_in_bit) begin
                r_tick <= w_tick_nxt;
                if (w_tick_nxt == TICK_SAMPLE_0) r_samp[0] <= r_rx_s;
                if (w_tick_nxt == TICK_SAMPLE_1) r_samp[1] <= r_rx_s;
            end

            case (r_state)
                RX_IDLE: begin
                    if (baud_16_x_p && !r_rx_s) begin
                        r_state   <= RX_START;
                        r_tick    <= 4'd0;
                        r_bit_cnt <= 3'd0;
                    end
                end
                RX_START: begin
                    if (baud_16_x_p) begin
                        if (w_tick_nxt == TICK_SAMPLE_2 && w_maj) begin
                            r_state <= RX_IDLE;
                        end else if (w_tick_nxt == TICK_LAST) begin
                            r_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (baud_16_x_p) begin
                        if (w_tick_nxt == TICK_SAMPLE_2) begin
                            r_shift <= {w_maj, r_shift[7:1]};
                        end
                        if (w_tick_nxt == TICK_LAST) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= RX_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                RX_STOP: begin
                    if (baud_16_x_p && w_tick_nxt == TICK_SAMPLE_2) begin
                        if (w_maj) begin
                            r_state <= RX_PUSH;
                        end else begin
                            r_framing_err <= 1'b1;
                            r_state       <= RX_BREAK;
                        end
                    end
                end
                RX_PUSH: begin
                    if (!bus.fifo_rx_full_p) begin
                        r_wr_en <= 1'b1;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= RX_IDLE;
                end
                RX_BREAK: begin
                    if (baud_16_x_p && r_rx_s) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    fifo_rx #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo_rx (
        .i_clk       (clk210_p),
        .i_rst       (reset_p),
        .i_wr_en     (r_wr_en),
        .i_wr_data   (r_shift),
        .i_rd_en     (bus.fifo_rx_rd_en_p),
        .o_dout      (bus.fifo_rx_dout_p),
        .o_data_count(bus.fifo_rx_data_count_p),
        .o_empty     (bus.fifo_rx_empty_p),
        .o_full      (bus.fifo_rx_full_p)
    );

    assign bus.rx_byte_valid_p = r_valid;
    assign bus.framing_error_p = r_framing_err;
    assign bus.overrun_p       = r_overrun;

endmodule
